// File: rtl/dram_word_bridge.sv
// ---------------------------------------------------------------------------
// dram_word_bridge
//
// Converts CPU 32-bit word accesses with byte strobes into 128-bit line
// transactions for a DRAM controller that has no byte masking. A single
// line buffer holds the last line fetched or written:
//   - read hits are answered from the buffer in one cycle,
//   - read misses fetch the line,
//   - write hits merge into the buffer and write the whole line back,
//   - write misses fetch, merge, then write the line back (read-modify-write).
// Every write goes straight through to DRAM, so the buffer is never dirty.
//
// Parameters
//   HIT_EN   1: buffer hits bypass DRAM; 0: every access goes to DRAM
//   ADDR_HI  top address bit of the tag (tag = cpu_addr[ADDR_HI:4])
//
// Ports
//   clk, rstn            clock (rising edge), async active-low reset
//   cpu_valid/cpu_ready  CPU request / one-cycle completion pulse
//   cpu_addr             byte address, [1:0] ignored
//   cpu_wstrb            byte enables, 4'b0000 = read
//   cpu_wdata/cpu_rdata  write data / read data (valid with cpu_ready)
//   flush                invalidate the line buffer
//   mem_valid/mem_ready  controller request / one-cycle completion pulse
//   mem_addr             line address {addr[31:4], 4'h0}
//   mem_wmask            1 = line write, 0 = line read
//   mem_wdata/mem_rdata  128-bit line write / read data
// ---------------------------------------------------------------------------
module dram_word_bridge #(
  parameter bit HIT_EN  = 1'b1,
  parameter int ADDR_HI = 31
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         cpu_valid,
  output logic         cpu_ready,
  input  logic [31:0]  cpu_addr,
  input  logic [3:0]   cpu_wstrb,
  input  logic [31:0]  cpu_wdata,
  output logic [31:0]  cpu_rdata,
  input  logic         flush,
  output logic         mem_valid,
  input  logic         mem_ready,
  output logic [31:0]  mem_addr,
  output logic         mem_wmask,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata
);

  localparam int TAG_W = ADDR_HI - 3;

  typedef enum logic [1:0] {
    S_IDLE,   // waiting for a CPU request; serves read hits directly
    S_FILL,   // line read outstanding
    S_MERGE,  // one cycle to merge strobed bytes into the fetched line
    S_WRITE   // line write outstanding
  } state_t;

  state_t state_q, state_d;

  // Line buffer
  logic               line_vld;
  logic [TAG_W-1:0]   line_tag;
  logic [127:0]       line_buf;

  // Request captured when leaving S_IDLE; CPU inputs are ignored afterwards
  logic [31:4]        req_line;
  logic [1:0]         req_lane;
  logic [3:0]         req_wstrb;
  logic [31:0]        req_wdata;

  logic               req_q;
  logic               flush_pend;

  logic               hit;
  logic               use_hit;
  logic               accept;
  logic               cpu_write;
  logic               req_write;
  logic [127:0]       merged_cpu;
  logic [127:0]       merged_req;

  // Address bits below the word are not needed anywhere.
  logic               unused_addr_lsb;
  assign unused_addr_lsb = ^cpu_addr[1:0];

  // -------------------------------------------------------------------------
  // Lane helpers: word k lives in line bits [32k+31:32k], byte b of that word
  // in [32k+8b+7:32k+8b].
  // -------------------------------------------------------------------------
  function automatic logic [31:0] lane_of(input logic [127:0] line,
                                          input logic [1:0]   k);
    logic [31:0] w;
    case (k)
      2'd0:    w = line[31:0];
      2'd1:    w = line[63:32];
      2'd2:    w = line[95:64];
      default: w = line[127:96];
    endcase
    return w;
  endfunction

  function automatic logic [127:0] merge_word(input logic [127:0] line,
                                              input logic [1:0]   k,
                                              input logic [3:0]   strb,
                                              input logic [31:0]  data);
    logic [127:0] res;
    res = line;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[{k, 2'(b), 3'b000} +: 8] = data[8*b +: 8];
    end
    return res;
  endfunction

  // -------------------------------------------------------------------------
  // Request classification
  // -------------------------------------------------------------------------
  assign hit       = HIT_EN && line_vld && (line_tag == cpu_addr[ADDR_HI:4]);
  // A flush in the same cycle wins over the hit, so the access goes to DRAM.
  assign use_hit   = hit && !flush;
  // cpu_valid is still high during the cpu_ready cycle for the request just
  // finished; it must not be taken as a new one.
  assign accept    = (state_q == S_IDLE) && cpu_valid && !cpu_ready;
  assign cpu_write = |cpu_wstrb;
  assign req_write = |req_wstrb;

  assign merged_cpu = merge_word(line_buf, cpu_addr[3:2], cpu_wstrb, cpu_wdata);
  assign merged_req = merge_word(line_buf, req_lane, req_wstrb, req_wdata);

  // The controller samples valid again right after its ready pulse, so the
  // request is withdrawn combinationally in the ready cycle itself.
  assign mem_valid = req_q & ~mem_ready;
  assign mem_addr  = {req_line, 4'h0};

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // -------------------------------------------------------------------------
  // FSM next state
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: assign a default before the case so no path leaves state_d
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (cpu_write)     state_d = use_hit ? S_WRITE : S_FILL;
          else if (!use_hit) state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (mem_ready) state_d = req_write ? S_MERGE : S_IDLE;
      end
      S_MERGE: state_d = S_WRITE;
      S_WRITE: begin
        if (mem_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath and buffer
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: line_buf is a single flop-based line rather than a RAM, so it is
      // reset along with everything else; mem_wdata and cpu_rdata never carry
      // X after reset.
      line_vld   <= 1'b0;
      line_tag   <= '0;
      line_buf   <= '0;
      req_line   <= '0;
      req_lane   <= '0;
      req_wstrb  <= '0;
      req_wdata  <= '0;
      req_q      <= 1'b0;
      flush_pend <= 1'b0;
      cpu_ready  <= 1'b0;
      cpu_rdata  <= '0;
      mem_wmask  <= 1'b0;
      mem_wdata  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // right-hand side sees the pre-edge value regardless of statement order.
      cpu_ready <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (flush) line_vld <= 1'b0;
          if (accept) begin
            req_line  <= cpu_addr[31:4];
            req_lane  <= cpu_addr[3:2];
            req_wstrb <= cpu_wstrb;
            req_wdata <= cpu_wdata;
            if (use_hit && !cpu_write) begin
              cpu_ready <= 1'b1;
              cpu_rdata <= lane_of(line_buf, cpu_addr[3:2]);
            end else if (use_hit && cpu_write) begin
              // Hit write: no fill needed, write the merged line straight out.
              line_buf  <= merged_cpu;
              mem_wdata <= merged_cpu;
              mem_wmask <= 1'b1;
              req_q     <= 1'b1;
            end else begin
              // Any miss, read or write, starts with a line fetch.
              mem_wmask <= 1'b0;
              req_q     <= 1'b1;
            end
          end
        end

        S_FILL: begin
          if (mem_ready) begin
            req_q    <= 1'b0;
            line_buf <= mem_rdata;
            line_tag <= req_line[ADDR_HI:4];
            line_vld <= 1'b1;
            if (!req_write) begin
              cpu_ready <= 1'b1;
              cpu_rdata <= lane_of(mem_rdata, req_lane);
            end
          end
        end

        S_MERGE: begin
          line_buf  <= merged_req;
          mem_wdata <= merged_req;
          mem_wmask <= 1'b1;
          req_q     <= 1'b1;
        end

        S_WRITE: begin
          if (mem_ready) begin
            req_q     <= 1'b0;
            cpu_ready <= 1'b1;
            cpu_rdata <= '0;
          end
        end

        default: ;
      endcase

      // A flush seen while busy is held and applied when the access finishes.
      // NOTE: this clear of line_vld comes after the fill's set above, and the
      // last non-blocking assignment in the block wins, so the flush lands
      // after the buffer update for the access.
      if (state_q != S_IDLE) begin
        if (state_d == S_IDLE) begin
          flush_pend <= 1'b0;
          if (flush_pend || flush) line_vld <= 1'b0;
        end else if (flush) begin
          flush_pend <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dram_word_bridge.sv
// ---------------------------------------------------------------------------
// tb_dram_word_bridge
//
// Self-checking bench for dram_word_bridge. A behavioural DRAM controller
// serves line reads/writes from a sparse line store with a configurable
// latency. Expected CPU results and expected controller transactions are
// queued when stimulus is issued and compared when the DUT produces them.
// ---------------------------------------------------------------------------
module tb_dram_word_bridge;

  typedef struct packed {
    logic [31:0]  addr;
    logic         wmask;
    logic [127:0] wdata;
  } mem_txn_t;

  logic         clk = 1'b0;
  logic         rstn;
  logic         cpu_valid;
  logic         cpu_ready;
  logic [31:0]  cpu_addr;
  logic [3:0]   cpu_wstrb;
  logic [31:0]  cpu_wdata;
  logic [31:0]  cpu_rdata;
  logic         flush;
  logic         mem_valid;
  logic         mem_ready;
  logic [31:0]  mem_addr;
  logic         mem_wmask;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;

  logic         model_ready;
  logic         stray_ready;
  assign mem_ready = model_ready | stray_ready;

  int checks = 0;
  int errors = 0;
  int txn_cnt = 0;
  int lat_cfg = 2;
  bit hold_extra = 1'b0;
  bit model_busy = 1'b0;

  logic [31:0] exp_cpu_q [$];
  mem_txn_t    exp_mem_q [$];
  logic [127:0] dram [logic [27:0]];

  always #5 clk = ~clk;

  dram_word_bridge #(.HIT_EN(1'b1), .ADDR_HI(31)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cpu_valid (cpu_valid),
    .cpu_ready (cpu_ready),
    .cpu_addr  (cpu_addr),
    .cpu_wstrb (cpu_wstrb),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .flush     (flush),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wmask (mem_wmask),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  function automatic logic [127:0] dram_rd(input logic [27:0] idx);
    if (dram.exists(idx)) return dram[idx];
    return '0;
  endfunction

  function automatic mem_txn_t mk_txn(input logic [31:0] a, input logic w,
                                      input logic [127:0] d);
    mem_txn_t t;
    t.addr  = a;
    t.wmask = w;
    t.wdata = d;
    return t;
  endfunction

  // -------------------------------------------------------------------------
  // Controller model: sees a request at a falling edge, answers lat_cfg
  // cycles later with a one-cycle ready (two cycles when hold_extra is set).
  // -------------------------------------------------------------------------
  initial begin : ctrl_model
    mem_txn_t got;
    mem_txn_t exp_t;
    model_ready = 1'b0;
    mem_rdata   = '0;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && mem_valid === 1'b1) begin
        model_busy = 1'b1;
        got = mk_txn(mem_addr, mem_wmask, mem_wdata);
        txn_cnt++;
        checks++;
        if (exp_mem_q.size() == 0) begin
          errors++;
          $display("FAIL mem_txn unexpected request addr=%h wmask=%b", got.addr, got.wmask);
        end else begin
          exp_t = exp_mem_q.pop_front();
          if (got.addr !== exp_t.addr || got.wmask !== exp_t.wmask ||
              (exp_t.wmask && got.wdata !== exp_t.wdata)) begin
            errors++;
            $display("FAIL mem_txn got addr=%h wmask=%b wdata=%h exp addr=%h wmask=%b wdata=%h",
                     got.addr, got.wmask, got.wdata, exp_t.addr, exp_t.wmask, exp_t.wdata);
          end
        end
        if (got.wmask) dram[got.addr[31:4]] = got.wdata;
        repeat (lat_cfg) @(negedge clk);
        mem_rdata   = dram_rd(got.addr[31:4]);
        model_ready = 1'b1;
        #1;
        checks++;
        if (mem_valid !== 1'b0) begin
          errors++;
          $display("FAIL mem_valid_drop got=%b exp=0 in ready cycle", mem_valid);
        end
        @(negedge clk);
        if (hold_extra) begin
          #1;
          checks++;
          if (mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL dup_request mem_valid got=%b exp=0 while ready held", mem_valid);
          end
          @(negedge clk);
        end
        model_ready = 1'b0;
        mem_rdata   = '0;
        model_busy  = 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------
  task automatic cpu_access(input logic [31:0] addr, input logic [3:0] strb,
                            input logic [31:0] wdata, input logic [31:0] exp_rdata,
                            input logic do_flush, input string name, output int lat);
    logic [31:0] exp_v;
    bit done;
    done = 1'b0;
    exp_cpu_q.push_back(exp_rdata);
    cpu_addr  = addr;
    cpu_wstrb = strb;
    cpu_wdata = wdata;
    cpu_valid = 1'b1;
    if (do_flush) flush = 1'b1;
    lat = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (do_flush && i == 0) flush = 1'b0;
      lat++;
      if (cpu_ready === 1'b1) begin
        done  = 1'b1;
        exp_v = exp_cpu_q.pop_front();
        checks++;
        if (cpu_rdata !== exp_v) begin
          errors++;
          $display("FAIL %s rdata got=%h exp=%h", name, cpu_rdata, exp_v);
        end
      end
    end
    cpu_valid = 1'b0;
    cpu_wstrb = 4'h0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no cpu_ready within 60 cycles", name);
      void'(exp_cpu_q.pop_front());
      lat = -1;
    end
  endtask

  task automatic wait_mem_valid(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (mem_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s mem_valid never rose within 40 cycles", name);
    end
  endtask

  task automatic check_txns(input string name, input int t0, input int exp_n);
    checks++;
    if (txn_cnt - t0 != exp_n) begin
      errors++;
      $display("FAIL %s txn_count got=%0d exp=%0d", name, txn_cnt - t0, exp_n);
    end
    checks++;
    if (exp_mem_q.size() != 0) begin
      errors++;
      $display("FAIL %s missing_txns got=%0d outstanding exp=0", name, exp_mem_q.size());
      exp_mem_q.delete();
    end
  endtask

  task automatic check_lat(input string name, input int lat, input int exp_lat);
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL %s latency got=%0d exp=%0d", name, lat, exp_lat);
    end
  endtask

  // -------------------------------------------------------------------------
  // Tests
  // -------------------------------------------------------------------------
  task automatic test_reset();
    int t0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (cpu_ready !== 1'b0) begin errors++; $display("FAIL reset cpu_ready got=%b exp=0", cpu_ready); end
    checks++;
    if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset cpu_rdata got=%h exp=0", cpu_rdata); end
    checks++;
    if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset mem_valid got=%b exp=0", mem_valid); end
    checks++;
    if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset mem_addr got=%h exp=0", mem_addr); end
    checks++;
    if (mem_wmask !== 1'b0) begin errors++; $display("FAIL reset mem_wmask got=%b exp=0", mem_wmask); end
    checks++;
    if (mem_wdata !== 128'h0) begin errors++; $display("FAIL reset mem_wdata got=%h exp=0", mem_wdata); end
    // A stray ready pulse in idle must be ignored.
    t0 = txn_cnt;
    stray_ready = 1'b1;
    @(negedge clk);
    stray_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (cpu_ready !== 1'b0) begin errors++; $display("FAIL stray_ready cpu_ready got=%b exp=0", cpu_ready); end
    check_txns("stray_ready", t0, 0);
  endtask

  task automatic test_read_miss();
    int t0, lat;
    dram[28'h0000010] = 128'h33333333_22222222_11111111_00000000;
    t0 = txn_cnt;
    exp_mem_q.push_back(mk_txn(32'h0000_0100, 1'b0, '0));
    cpu_access(32'h0000_0104, 4'h0, 32'h0, 32'h11111111, 1'b0, "read_miss", lat);
    check_txns("read_miss", t0, 1);
  endtask

  task automatic test_read_hit();
    int t0, lat;
    @(negedge clk);
    t0 = txn_cnt;
    cpu_access(32'h0000_010C, 4'h0, 32'h0, 32'h33333333, 1'b0, "read_hit", lat);
    check_lat("read_hit", lat, 1);
    check_txns("read_hit", t0, 0);
  endtask

  task automatic test_write_hit();
    int t0, lat;
    @(negedge clk);
    t0 = txn_cnt;
    exp_mem_q.push_back(mk_txn(32'h0000_0100, 1'b1,
                               128'h33333333_22BB22DD_11111111_00000000));
    cpu_access(32'h0000_0108, 4'b0101, 32'hAABBCCDD, 32'h0, 1'b0, "write_hit", lat);
    check_txns("write_hit", t0, 1);
    @(negedge clk);
    t0 = txn_cnt;
    cpu_access(32'h0000_0108, 4'h0, 32'h0, 32'h22BB22DD, 1'b0, "write_hit_readback", lat);
    check_lat("write_hit_readback", lat, 1);
    check_txns("write_hit_readback", t0, 0);
  endtask

  task automatic test_back_to_back();
    int t0, lat;
    @(negedge clk);
    t0 = txn_cnt;
    cpu_access(32'h0000_0100, 4'h0, 32'h0, 32'h00000000, 1'b0, "b2b_first", lat);
    check_lat("b2b_first", lat, 1);
    // Issued in the cpu_ready cycle: must wait one extra cycle.
    cpu_access(32'h0000_0108, 4'h0, 32'h0, 32'h22BB22DD, 1'b0, "b2b_second", lat);
    check_lat("b2b_second", lat, 2);
    check_txns("b2b", t0, 0);
  endtask

  task automatic test_write_miss();
    int t0, lat;
    @(negedge clk);
    t0 = txn_cnt;
    exp_mem_q.push_back(mk_txn(32'h0000_2000, 1'b0, '0));
    exp_mem_q.push_back(mk_txn(32'h0000_2000, 1'b1, 128'h0000_0000_0000_0000_0000_0000_EE00_0000));
    fork
      cpu_access(32'h0000_2000, 4'b1000, 32'hEE000000, 32'h0, 1'b0, "write_miss", lat);
      begin
        // CPU inputs changing while busy must not affect the merge.
        wait_mem_valid("write_miss_fill");
        cpu_addr  = 32'h0000_200C;
        cpu_wdata = 32'hFFFFFFFF;
      end
    join
    check_txns("write_miss", t0, 2);
    @(negedge clk);
    t0 = txn_cnt;
    cpu_access(32'h0000_2000, 4'h0, 32'h0, 32'hEE000000, 1'b0, "write_miss_tag_hit", lat);
    check_lat("write_miss_tag_hit", lat, 1);
    check_txns("write_miss_tag_hit", t0, 0);
    @(negedge clk);
    t0 = txn_cnt;
    exp_mem_q.push_back(mk_txn(32'h0000_0100, 1'b0, '0));
    cpu_access(32'h0000_0104, 4'h0, 32'h0, 32'h11111111, 1'b0, "old_line_miss", lat);
    check_txns("old_line_miss", t0, 1);
  endtask

  task automatic test_hold_ready();
    int t0, lat;
    hold_extra = 1'b1;
    dram[28'h0000030] = 128'h0F0F0F0F_0E0E0E0E_0D0D0D0D_0C0C0C0C;
    dram[28'h0000050] = 128'h44444444_33333333_22222222_11111111;
    @(negedge clk);
    t0 = txn_cnt;
    exp_mem_q.push_back(mk_txn(32'h0000_0300, 1'b0, '0));
    cpu_access(32'h0000_0308, 4'h0, 32'h0, 32'h0E0E0E0E, 1'b0, "hold_read", lat);
    repeat (2) @(negedge clk);
    check_txns("hold_read", t0, 1);
    t0 = txn_cnt;
    exp_mem_q.push_back(mk_txn(32'h0000_0500, 1'b0, '0));
    exp_mem_q.push_back(mk_txn(32'h0000_0500, 1'b1, 128'h44444444_33333333_2222BEEF_11111111));
    cpu_access(32'h0000_0504, 4'b0011, 32'h1234BEEF, 32'h0, 1'b0, "hold_write", lat);
    repeat (2) @(negedge clk);
    check_txns("hold_write", t0, 2);
    hold_extra = 1'b0;
  endtask

  task automatic test_flush();
    int t0, lat;
    dram[28'h0000040] = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    lat_cfg = 3;
    @(negedge clk);
    t0 = txn_cnt;
    exp_mem_q.push_back(mk_txn(32'h0000_0400, 1'b0, '0));
    fork
      cpu_access(32'h0000_0404, 4'h0, 32'h0, 32'hBBBBBBBB, 1'b0, "flush_in_fill", lat);
      begin
        wait_mem_valid("flush_in_fill");
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
      end
    join
    check_txns("flush_in_fill", t0, 1);
    lat_cfg = 2;
    @(negedge clk);
    t0 = txn_cnt;
    exp_mem_q.push_back(mk_txn(32'h0000_0400, 1'b0, '0));
    cpu_access(32'h0000_040C, 4'h0, 32'h0, 32'hDDDDDDDD, 1'b0, "reread_after_flush", lat);
    check_txns("reread_after_flush", t0, 1);
    // Flush together with what would be a hit: treated as a miss.
    @(negedge clk);
    t0 = txn_cnt;
    exp_mem_q.push_back(mk_txn(32'h0000_0400, 1'b0, '0));
    cpu_access(32'h0000_0408, 4'h0, 32'h0, 32'hCCCCCCCC, 1'b1, "flush_on_hit", lat);
    check_txns("flush_on_hit", t0, 1);
    @(negedge clk);
    t0 = txn_cnt;
    cpu_access(32'h0000_0400, 4'h0, 32'h0, 32'hAAAAAAAA, 1'b0, "hit_after_refill", lat);
    check_lat("hit_after_refill", lat, 1);
    check_txns("hit_after_refill", t0, 0);
  endtask

  task automatic test_reset_mid_write();
    int t0, lat;
    bit idle;
    @(negedge clk);
    exp_mem_q.push_back(mk_txn(32'h0000_0400, 1'b1, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_12345678));
    cpu_addr  = 32'h0000_0400;
    cpu_wstrb = 4'hF;
    cpu_wdata = 32'h12345678;
    cpu_valid = 1'b1;
    wait_mem_valid("reset_mid_write");
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (mem_valid !== 1'b0) begin errors++; $display("FAIL rst_mid mem_valid got=%b exp=0", mem_valid); end
    checks++;
    if (cpu_ready !== 1'b0) begin errors++; $display("FAIL rst_mid cpu_ready got=%b exp=0", cpu_ready); end
    checks++;
    if (mem_wmask !== 1'b0) begin errors++; $display("FAIL rst_mid mem_wmask got=%b exp=0", mem_wmask); end
    checks++;
    if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mid mem_addr got=%h exp=0", mem_addr); end
    cpu_valid = 1'b0;
    cpu_wstrb = 4'h0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    idle = 1'b0;
    for (int i = 0; i < 20 && !idle; i++) begin
      @(negedge clk);
      if (!model_busy) idle = 1'b1;
    end
    checks++;
    if (!idle) begin errors++; $display("FAIL rst_mid controller still busy after 20 cycles exp idle"); end
    checks++;
    if (exp_mem_q.size() != 0) begin
      errors++;
      $display("FAIL rst_mid write_txn outstanding=%0d exp=0", exp_mem_q.size());
      exp_mem_q.delete();
    end
    // Buffer was invalidated: same line must miss and refetch.
    @(negedge clk);
    t0 = txn_cnt;
    exp_mem_q.push_back(mk_txn(32'h0000_0400, 1'b0, '0));
    cpu_access(32'h0000_0400, 4'h0, 32'h0, 32'h12345678, 1'b0, "read_after_reset", lat);
    check_txns("read_after_reset", t0, 1);
  endtask

  // -------------------------------------------------------------------------
  // Sequence
  // -------------------------------------------------------------------------
  initial begin
    rstn        = 1'b0;
    cpu_valid   = 1'b0;
    cpu_addr    = '0;
    cpu_wstrb   = '0;
    cpu_wdata   = '0;
    flush       = 1'b0;
    stray_ready = 1'b0;
    test_reset();
    test_read_miss();
    test_read_hit();
    test_write_hit();
    test_back_to_back();
    test_write_miss();
    test_hold_ready();
    test_flush();
    test_reset_mid_write();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish within 500000 time units");
    $fatal(1, "watchdog");
  end

endmodule
